chan_mux: RTL and testbench

Parametrised, registered N-channel stream multiplexer. It merges `N_CH` valid/ready input channels of `WIDTH` bits onto one output stream. Channel choice is either a manual select or round-robin arbitration with bounded burst locking. It replaces the fixed-width combinational 3-input select muxes in the datapath wherever sources are independent producers that need flow control.

---
 rtl/chan_mux_pkg.sv | 13 +
 rtl/rr_pick.sv | 25 ++
 rtl/chan_mux.sv | 137 +++++++++++++
 tb/tb_chan_mux.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the channel multiplexer and its arbiter.
package chan_mux_pkg;

  // Arbiter state: free to pick a new channel, or locked onto ptr for a burst.
  typedef enum logic [0:0] {
    CM_IDLE = 1'b0,
    CM_LOCK = 1'b1
  } cm_state_e;

  localparam logic CM_MODE_SEL = 1'b0;
  localparam logic CM_MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: returns the first set request found from base+1
// upward, wrapping modulo N_CH. base itself has the lowest priority.
module rr_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Scan from farthest to nearest so the nearest hit wins the last assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      if (req[(int'(base) + k) % N_CH]) begin
        idx   = SEL_W'((int'(base) + k) % N_CH);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux.sv
// Registered N-channel valid/ready stream multiplexer with manual select or
// round-robin arbitration with bounded burst locking.
module chan_mux
  import chan_mux_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int SEL_W     = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  input  logic [N_CH-1:0][WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]            in_valid,
  output logic [N_CH-1:0]            in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEL_W-1:0]           out_ch
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);

  cm_state_e        state;
  logic [SEL_W-1:0] ptr;
  logic [BW-1:0]    burst_cnt;
  logic [BW-1:0]    burst_nxt;
  logic             mode_q;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             load;
  logic             xfer;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req   (in_valid),
    .base  (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign load      = !out_valid || out_ready;
  assign burst_nxt = burst_cnt + BW'(1);

  // Grant selection; always follows the current mode input, even on a mode change.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (mode == CM_MODE_SEL) begin
      grant     = sel;
      grant_vld = (32'(sel) < N_CH);
    end else if (state == CM_LOCK) begin
      grant     = ptr;
      grant_vld = 1'b1;
    end else begin
      grant     = pick_idx;
      grant_vld = pick_found;
    end
  end

  // A beat moves only from the granted channel when the output stage can take it.
  assign xfer = grant_vld && load && in_valid[grant];

  // One-hot (or zero) ready toward the granted channel; quiet during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = !rst && load && grant_vld && (grant == SEL_W'(i));
    end
  end

  // Arbiter FSM: pointer, burst counter and lock state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CM_IDLE;
      ptr       <= SEL_W'(N_CH - 1);
      burst_cnt <= '0;
      mode_q    <= mode;
    end else begin
      mode_q <= mode;
      if (mode != mode_q) begin
        state <= CM_IDLE;
        // Keep round-robin fairness if the first new-mode beat came from the arbiter.
        if (mode == CM_MODE_RR && xfer) begin
          ptr       <= grant;
          burst_cnt <= BW'(1);
        end
      end else if (mode == CM_MODE_RR) begin
        unique case (state)
          CM_IDLE: begin
            if (xfer) begin
              ptr       <= grant;
              burst_cnt <= BW'(1);
              if (MAX_BURST > 1) state <= CM_LOCK;
            end
          end
          CM_LOCK: begin
            // Stall cycles (load low) leave everything untouched.
            if (load) begin
              if (xfer) begin
                burst_cnt <= burst_nxt;
                if (burst_nxt >= BURST_LAST) state <= CM_IDLE;
              end else if (!in_valid[ptr]) begin
                state <= CM_IDLE;
              end
            end
          end
          default: state <= CM_IDLE;
        endcase
      end
    end
  end

  // Output register: load a new beat, or drain when downstream accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant];
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_mux.sv
// Directed bench for chan_mux: a 4-channel build for the main scenarios and a
// 5-channel build for out-of-range manual select.
module tb_chan_mux;

  logic            clk;
  logic            rst;
  logic            mode;
  logic [1:0]      sel;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_ch;

  logic            mode5;
  logic [2:0]      sel5;
  logic [4:0][7:0] in_data5;
  logic [4:0]      in_valid5;
  logic [4:0]      in_ready5;
  logic [7:0]      out_data5;
  logic            out_valid5;
  logic            out_ready5;
  logic [2:0]      out_ch5;

  int n_tests = 0;
  int n_fail  = 0;

  chan_mux #(
    .N_CH      (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  chan_mux #(
    .N_CH      (5),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut5 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode5),
    .sel       (sel5),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_ch    (out_ch5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch_data(input int c);
    return 8'((c + 1) * 16);
  endfunction

  initial begin
    rst        = 1'b1;
    mode       = 1'b1;
    sel        = 2'd0;
    in_valid   = 4'hF;
    out_ready  = 1'b1;
    in_data    = {8'h40, 8'h30, 8'h20, 8'h10};
    mode5      = 1'b0;
    sel5       = 3'd0;
    in_valid5  = 5'h1F;
    in_data5   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    out_ready5 = 1'b1;

    // Reset held two cycles with everything valid.
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    chk("rst_in_ready5", in_ready5, 0);

    // Round-robin bursts of 4 with all channels valid.
    rst = 1'b0;
    #1;
    chk("rr_first_ready", in_ready, 4'b0001);
    for (int k = 0; k < 17; k++) begin
      tick();
      chk("rr_out_ch", out_ch, (k / 4) % 4);
      chk("rr_out_data", out_data, ch_data((k / 4) % 4));
      chk("rr_out_valid", out_valid, 1);
    end

    // Manual select on the 4-channel build.
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    mode       = 1'b0;
    sel        = 2'd2;
    in_valid   = 4'b0100;
    in_data[2] = 8'hA5;
    #1;
    chk("sel_in_ready", in_ready, 4'b0100);
    tick();
    chk("sel_out_data", out_data, 8'hA5);
    chk("sel_out_ch", out_ch, 2);
    chk("sel_out_valid", out_valid, 1);
    in_data[2] = 8'h30;

    // Manual select on the 5-channel build, including indices past the last channel.
    sel5 = 3'd4;
    #1;
    chk("sel5_ready_4", in_ready5, 5'b10000);
    tick();
    chk("sel5_out_ch", out_ch5, 4);
    chk("sel5_out_data", out_data5, 8'h55);
    sel5 = 3'd5;
    #1;
    chk("sel5_ready_5", in_ready5, 0);
    sel5 = 3'd7;
    #1;
    chk("sel5_ready_7", in_ready5, 0);
    tick();
    chk("sel5_drained", out_valid5, 0);

    // Early release: channel 1 locked for 2 beats, then drops; channel 3 takes over.
    rst      = 1'b1;
    mode     = 1'b1;
    in_valid = 4'b0010;
    tick();
    rst = 1'b0;
    #1;
    chk("er_first_ready", in_ready, 4'b0010);
    tick();
    chk("er_beat1_ch", out_ch, 1);
    tick();
    chk("er_beat2_ch", out_ch, 1);
    in_valid = 4'b1000;
    #1;
    chk("er_lock_ready", in_ready, 4'b0010);
    tick();
    chk("er_gap_valid", out_valid, 0);
    chk("er_idle_ready", in_ready, 4'b1000);
    tick();
    chk("er_ch3_ch", out_ch, 3);
    chk("er_ch3_valid", out_valid, 1);
    in_valid = 4'b1010;
    #1;
    chk("er_ch3_lock_ready", in_ready, 4'b1000);
    tick();
    chk("er_ch3_again", out_ch, 3);

    // Backpressure mid-burst: outputs hold, ready drops, stall cycles do not count.
    rst      = 1'b1;
    in_valid = 4'hF;
    tick();
    rst = 1'b0;
    tick();
    chk("bp_beat1_ch", out_ch, 0);
    tick();
    chk("bp_beat2_ch", out_ch, 0);
    out_ready  = 1'b0;
    in_data[0] = 8'hEE;
    #1;
    chk("bp_ready_low", in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_hold_data", out_data, 8'h10);
      chk("bp_hold_ch", out_ch, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready  = 1'b1;
    in_data[0] = 8'h10;
    tick();
    chk("bp_beat3_ch", out_ch, 0);
    tick();
    chk("bp_beat4_ch", out_ch, 0);
    tick();
    chk("bp_next_ch", out_ch, 1);

    // Mode switch 1->0 after 2 beats of channel 0, then reset with a beat held.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("ms_beat2_ch", out_ch, 0);
    mode = 1'b0;
    sel  = 2'd3;
    #1;
    chk("ms_ready", in_ready, 4'b1000);
    tick();
    chk("ms_out_ch", out_ch, 3);
    chk("ms_out_data", out_data, 8'h40);
    chk("ms_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("ms_rst_ready", in_ready, 0);
    tick();
    chk("ms_rst_valid", out_valid, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
